sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the synchronous successor to the team's 32x128 FIFO. Adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, sticky error flags with clear, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks that share one clock domain.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 128, number of entries; power of two, >=4
AF_LEVEL, DEPTH-4, almost_full asserted when status >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserted when status <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on data_read while not empty

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
write_flag  in  1  write request
data_write  in  DATA_W  write data, sampled with write_flag
read_flag  in  1  read (pop) request
data_read  out  DATA_W  read data
full  out  1  status == DEPTH
empty  out  1  status == 0
almost_full  out  1  status >= AF_LEVEL
almost_empty  out  1  status <= AE_LEVEL
status  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
err_write  out  1  sticky: a write was attempted while full
err_read  out  1  sticky: a read was attempted while empty
clear_err  in  1  clears err_write and err_read

Behaviour:
- Reset (rst_n low at a clk edge): wr_ptr=0, rd_ptr=0, status=0, data_read=0, err_write=0, err_read=0. Therefore empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset. Reset mid-operation discards all stored data; requests in the reset cycle are ignored.
- Pointers are $clog2(DEPTH) bits wide and wrap DEPTH-1 -> 0 naturally. The count is held separately.
- A write is accepted when write_flag && !full: mem[wr_ptr] <= data_write, wr_ptr+1.
- A read is accepted when read_flag && !empty: rd_ptr+1.
- Full/empty decisions use the registered status from before the edge. There is no same-cycle bypass:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
- Status update: +1 on a write alone, -1 on a read alone, unchanged when both or neither are accepted.
- Flags full, empty, almost_full and almost_empty are combinational compares of the registered status, so they are valid in the same cycle status updates.
- FWFT=0: on an accepted read, data_read <= mem[rd_ptr] at that edge, so data is visible the cycle after the request. Otherwise data_read holds its last value.
- FWFT=1: data_read = mem[rd_ptr] combinationally while !empty, and 0 while empty. An accepted read advances to the next word. A word written into an empty FIFO appears on data_read the cycle after the write.
- err_write is set on write_flag && full; err_read is set on read_flag && empty.
- clear_err clears both error flags. If a set and clear_err occur in the same cycle, set wins.
- Rejected requests never modify pointers, status or memory.

Decomposition:
- Package fifo_pkg: a function returning the occupancy width ($clog2(DEPTH)+1), default constants DATA_W_DEF=32 and DEPTH_DEF=128, and an elaboration check that DEPTH is a power of two and AE_LEVEL < AF_LEVEL <= DEPTH.
- One sub-module, fifo_mem: simple dual-port array with one synchronous write port and one asynchronous read port. The top level adds the data_read register for FWFT=0.

Test Plan:
1. DEPTH=8, FWFT=0: reset, then write 0xA0..0xA7 on 8 consecutive cycles -> status 1..8, full=1 after the 8th write, almost_full=1 from status 4 (AF_LEVEL=4), err_write=0.
2. Continue from 1: write 0xFF while full -> status stays 8, err_write=1. Then pulse clear_err -> err_write=0. Then read 8 times -> data_read=0xA0..0xA7, each one cycle after its read, empty=1 at the end.
3. Empty FIFO, read_flag for one cycle -> err_read=1, status=0, data_read unchanged. Then clear_err and a new read_flag in the same cycle -> err_read stays 1 (set wins).
4. Status=3, write 0x11 and read together for 10 cycles -> status stays 3. Pointers wrap past 7 and data order is preserved across the wrap.
5. FWFT=1: write 0x55 into an empty FIFO -> data_read=0x55 the next cycle with no read. Read once -> empty=1 and data_read=0.
6. With 5 entries stored, assert rst_n=0 for one cycle while write_flag=1 -> status=0, empty=1, errors 0, data_read=0; the write is ignored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 128;

    // Occupancy counter width: one extra bit so DEPTH itself is representable.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Legal configuration: power-of-two depth of at least 4 and ordered thresholds.
    function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
        return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: store the word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky error flags and selectable registered or first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_flag,
    input  logic [DATA_W-1:0]         data_write,
    input  logic                      read_flag,
    output logic [DATA_W-1:0]         data_read,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [occ_w(DEPTH)-1:0]   status,
    output logic                      err_write,
    output logic                      err_read,
    input  logic                      clear_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_w(DEPTH);

    localparam logic [OCC_W-1:0] C_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] C_AF   = OCC_W'(AF_LEVEL);
    localparam logic [OCC_W-1:0] C_AE   = OCC_W'(AE_LEVEL);

    if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("sync_fifo_param: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_status;
    logic              r_err_write;
    logic              r_err_read;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_mem_rdata;

    // Accept decisions look only at the pre-edge occupancy, so a simultaneous
    // read never makes room for a write into a full FIFO and vice versa.
    assign w_full   = (r_status == C_FULL);
    assign w_empty  = (r_status == '0);
    assign w_wr_acc = write_flag & ~w_full;
    assign w_rd_acc = read_flag & ~w_empty;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_write),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rdata)
    );

    // Pointers wrap naturally at DEPTH; occupancy tracked in its own counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_status <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_status <= r_status + OCC_W'(1);
                2'b01:   r_status <= r_status - OCC_W'(1);
                default: r_status <= r_status;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clear_err stays set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_write <= 1'b0;
            r_err_read  <= 1'b0;
        end else begin
            r_err_write <= (write_flag & w_full) | (r_err_write & ~clear_err);
            r_err_read  <= (read_flag & w_empty) | (r_err_read & ~clear_err);
        end
    end

    if (FWFT == 0) begin : g_registered_read
        logic [DATA_W-1:0] r_data_read;

        // Registered read: the head word lands in the output register on the pop edge.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_data_read <= '0;
            end else if (w_rd_acc) begin
                r_data_read <= w_mem_rdata;
            end
        end

        assign data_read = r_data_read;
    end else begin : g_fwft_read
        // Head word shown directly; forced to zero when nothing is stored.
        assign data_read = w_empty ? '0 : w_mem_rdata;
    end

    assign status       = r_status;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_status >= C_AF);
    assign almost_empty = (r_status <= C_AE);
    assign err_write    = r_err_write;
    assign err_read     = r_err_read;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: table of vectors for the registered-read FIFO, plus a short
// hand sequence for a first-word-fall-through instance.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = 4;
    localparam int AE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance signals
    logic          a_rst_n = 1'b0, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic [DW-1:0] a_din = '0, a_dout;
    logic          a_full, a_empty, a_af, a_ae, a_ew, a_er;
    logic [3:0]    a_st;

    // FWFT instance signals
    logic          b_rst_n = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic [DW-1:0] b_din = '0, b_dout;
    logic          b_full, b_empty, b_af, b_ae, b_ew, b_er;
    logic [3:0]    b_st;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_reg (
        .clk(clk), .rst_n(a_rst_n), .write_flag(a_wr), .data_write(a_din), .read_flag(a_rd),
        .data_read(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .status(a_st), .err_write(a_ew), .err_read(a_er), .clear_err(a_clr)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(b_rst_n), .write_flag(b_wr), .data_write(b_din), .read_flag(b_rd),
        .data_read(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .status(b_st), .err_write(b_ew), .err_read(b_er), .clear_err(b_clr)
    );

    typedef struct {
        logic        rstn;
        logic        wr;
        logic        rd;
        logic        clr;
        logic [7:0]  din;
        int          st;
        logic [7:0]  dout;
        logic        ew;
        logic        er;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic rstn, input logic wr, input logic rd, input logic clr,
                       input logic [7:0] din, input int st, input logic [7:0] dout,
                       input logic ew, input logic er, input string name);
        vec_t v;
        v.rstn = rstn; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.st = st; v.dout = dout; v.ew = ew; v.er = er; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Status plus the four flags it implies for DEPTH=8, AF=4, AE=2.
    task automatic chk_occ(input string name, input int st_act, input logic f, input logic e,
                           input logic af, input logic ae, input int st_exp);
        chk({name, ".status"}, st_act, st_exp);
        chk({name, ".full"}, int'(f), int'(st_exp == DP));
        chk({name, ".empty"}, int'(e), int'(st_exp == 0));
        chk({name, ".almost_full"}, int'(af), int'(st_exp >= AF));
        chk({name, ".almost_empty"}, int'(ae), int'(st_exp <= AE));
    endtask

    task automatic b_step(input logic wr, input logic rd, input logic [7:0] din);
        b_wr = wr; b_rd = rd; b_din = din;
        @(negedge clk);
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        // Reset, then fill 0xA0..0xA7
        add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, "reset");
        for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 8'hA0 + 8'(i), i + 1, 8'h00, 0, 0, "fill");
        add(1, 1, 0, 0, 8'hFF, 8, 8'h00, 1, 0, "wr_full");
        add(1, 0, 0, 1, 8'h00, 8, 8'h00, 0, 0, "clr_ew");
        for (int k = 0; k < 8; k++) add(1, 0, 1, 0, 8'h00, 7 - k, 8'hA0 + 8'(k), 0, 0, "drain");
        // Read while empty, then set-wins against clear
        add(1, 0, 1, 0, 8'h00, 0, 8'hA7, 0, 1, "rd_empty");
        add(1, 0, 0, 1, 8'h00, 0, 8'hA7, 0, 0, "clr_er");
        add(1, 0, 1, 1, 8'h00, 0, 8'hA7, 0, 1, "set_wins");
        add(1, 0, 0, 1, 8'h00, 0, 8'hA7, 0, 0, "clr_er2");
        // Occupancy 3, then simultaneous write/read across the pointer wrap
        add(1, 1, 0, 0, 8'h01, 1, 8'hA7, 0, 0, "pre3");
        add(1, 1, 0, 0, 8'h02, 2, 8'hA7, 0, 0, "pre3");
        add(1, 1, 0, 0, 8'h03, 3, 8'hA7, 0, 0, "pre3");
        for (int k = 0; k < 10; k++)
            add(1, 1, 1, 0, 8'h10 + 8'(k), 3, (k < 3) ? 8'(k + 1) : 8'h10 + 8'(k - 3), 0, 0, "wr_rd");
        add(1, 0, 1, 0, 8'h00, 2, 8'h17, 0, 0, "post_wrap");
        add(1, 0, 1, 0, 8'h00, 1, 8'h18, 0, 0, "post_wrap");
        add(1, 0, 1, 0, 8'h00, 0, 8'h19, 0, 0, "post_wrap");
        // Read while empty is rejected even with an accepted write
        add(1, 1, 1, 0, 8'h33, 1, 8'h19, 0, 1, "wr_rd_empty");
        add(1, 0, 0, 1, 8'h00, 1, 8'h19, 0, 0, "clr_er3");
        for (int i = 0; i < 7; i++) add(1, 1, 0, 0, 8'h40 + 8'(i), 2 + i, 8'h19, 0, 0, "refill");
        // Write while full is rejected even with an accepted read
        add(1, 1, 1, 0, 8'hEE, 7, 8'h33, 1, 0, "wr_rd_full");
        add(1, 0, 1, 0, 8'h00, 6, 8'h40, 1, 0, "to5");
        add(1, 0, 1, 0, 8'h00, 5, 8'h41, 1, 0, "to5");
        // Reset mid-operation with a write request present
        add(0, 1, 0, 0, 8'h77, 0, 8'h00, 0, 0, "rst_mid");
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, "post_rst");
        add(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, "rd_after_rst");

        @(negedge clk);
        foreach (vecs[idx]) begin
            a_rst_n = vecs[idx].rstn;
            a_wr    = vecs[idx].wr;
            a_rd    = vecs[idx].rd;
            a_clr   = vecs[idx].clr;
            a_din   = vecs[idx].din;
            @(negedge clk);
            chk_occ(vecs[idx].name, int'(a_st), a_full, a_empty, a_af, a_ae, vecs[idx].st);
            chk({vecs[idx].name, ".data_read"}, int'(a_dout), int'(vecs[idx].dout));
            chk({vecs[idx].name, ".err_write"}, int'(a_ew), int'(vecs[idx].ew));
            chk({vecs[idx].name, ".err_read"}, int'(a_er), int'(vecs[idx].er));
        end
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;

        // FWFT sequence
        b_rst_n = 1'b0;
        @(negedge clk);
        b_rst_n = 1'b1;
        chk_occ("fwft_reset", int'(b_st), b_full, b_empty, b_af, b_ae, 0);
        chk("fwft_reset.data_read", int'(b_dout), 0);
        b_step(1'b1, 1'b0, 8'h55);
        chk("fwft_wr55.data_read", int'(b_dout), 'h55);
        chk_occ("fwft_wr55", int'(b_st), b_full, b_empty, b_af, b_ae, 1);
        b_step(1'b1, 1'b0, 8'h66);
        chk("fwft_wr66.data_read", int'(b_dout), 'h55);
        chk_occ("fwft_wr66", int'(b_st), b_full, b_empty, b_af, b_ae, 2);
        b_step(1'b0, 1'b1, 8'h00);
        chk("fwft_rd1.data_read", int'(b_dout), 'h66);
        chk_occ("fwft_rd1", int'(b_st), b_full, b_empty, b_af, b_ae, 1);
        b_step(1'b0, 1'b1, 8'h00);
        chk("fwft_rd2.data_read", int'(b_dout), 0);
        chk_occ("fwft_rd2", int'(b_st), b_full, b_empty, b_af, b_ae, 0);
        b_step(1'b0, 1'b1, 8'h00);
        chk("fwft_rd_empty.err_read", int'(b_er), 1);
        chk("fwft_rd_empty.data_read", int'(b_dout), 0);
        chk("fwft_rd_empty.err_write", int'(b_ew), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
